aes_shift_rows_pipe: RTL and testbench

Registered, parametrised ShiftRows / InvShiftRows stage for the cipher datapath. It generalises the fixed 128-bit combinational row shift in three ways: it supports Rijndael block widths of Nb = 4, 6 or 8 columns, it selects forward or inverse shift per beat, and it carries a tag alongside each state. It sits between SubBytes and MixColumns in the round pipeline. Upstream and downstream use valid/ready handshakes, and the stage holds a two-entry skid buffer so it sustains one beat per cycle with registered `in_ready`.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_shift_rows_pipe_if.sv | 28 ++
 rtl/aes_shift_rows_comb.sv | 31 +++
 rtl/aes_shift_rows_pipe.sv | 103 ++++++++++
 tb/tb_aes_shift_rows_pipe.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES round datapath: ShiftRows offsets, byte indexing,
// legal block widths and the skid-buffer occupancy encoding.
package aes_pkg;

    localparam int unsigned N_ROWS = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    function automatic bit nb_legal(input int unsigned nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Rijndael row offsets: rows 2 and 3 move one column further for the 256-bit block.
    function automatic int unsigned SHIFT_OFS(input int unsigned nb, input int unsigned row);
        if (nb == 8 && row >= 2) begin
            return row + 1;
        end
        return row;
    endfunction

    function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/aes_shift_rows_pipe_if.sv
// Valid/ready stream bundle for the ShiftRows stage; state is column-major, byte 0 in bits [0:7].
interface aes_shift_rows_pipe_if #(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned W = 32 * NB;

    logic             in_valid;
    logic             in_ready;
    logic [0:W-1]     in_state;
    logic             in_inv;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [0:W-1]     out_state;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_state, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_state, out_tag
    );

    modport slave (
        input  in_valid, in_state, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_state, out_tag
    );

endinterface

// File: rtl/aes_shift_rows_comb.sv
// Combinational ShiftRows / InvShiftRows for an NB-column state: fixed byte wiring
// plus one 2:1 mux per byte selected by inv.
module aes_shift_rows_comb
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [0:32*NB-1] in_state,
    input  logic             inv,
    output logic [0:32*NB-1] out_state_c
);

    if (!nb_legal(NB)) begin : g_nb_illegal
        $error("aes_shift_rows_comb: NB=%0d is not one of 4, 6, 8", NB);
    end

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < N_ROWS; r++) begin : g_row
            localparam int unsigned OFS   = SHIFT_OFS(NB, r);
            localparam int unsigned FWD_C = (c + OFS) % NB;
            localparam int unsigned INV_C = (c + NB - OFS) % NB;
            localparam int unsigned DST   = byte_idx(r, c);
            localparam int unsigned SRC_F = byte_idx(r, FWD_C);
            localparam int unsigned SRC_I = byte_idx(r, INV_C);

            assign out_state_c[8*DST +: 8] = inv ? in_state[8*SRC_I +: 8]
                                                 : in_state[8*SRC_F +: 8];
        end
    end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Registered ShiftRows stage: shift on the input side, then a two-entry skid buffer
// (main + skid) so in_ready stays registered at full throughput.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_shift_rows_pipe_if.slave bus
);

    localparam int unsigned W = 32 * NB;

    buf_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [0:W-1]     main_state_q, main_state_d;
    logic [0:W-1]     skid_state_q, skid_state_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic [0:W-1]     shifted_c;
    logic             accept_c;
    logic             pop_c;

    aes_shift_rows_comb #(.NB(NB)) u_shift (
        .in_state    (bus.in_state),
        .inv         (bus.in_inv),
        .out_state_c (shifted_c)
    );

    assign accept_c = bus.in_valid & in_ready_q;
    assign pop_c    = out_valid_q & bus.out_ready;

    // Occupancy FSM; both entries hold already-shifted state.
    always_comb begin
        state_d      = state_q;
        main_state_d = main_state_q;
        main_tag_d   = main_tag_q;
        skid_state_d = skid_state_q;
        skid_tag_d   = skid_tag_q;

        unique case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    main_state_d = shifted_c;
                    main_tag_d   = bus.in_tag;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (accept_c && !pop_c) begin
                    skid_state_d = shifted_c;
                    skid_tag_d   = bus.in_tag;
                    state_d      = TWO;
                end else if (!accept_c && pop_c) begin
                    state_d = EMPTY;
                end else if (accept_c && pop_c) begin
                    main_state_d = shifted_c;
                    main_tag_d   = bus.in_tag;
                end
            end
            TWO: begin
                if (pop_c) begin
                    main_state_d = skid_state_q;
                    main_tag_d   = skid_tag_q;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_state_q <= '0;
            main_tag_q   <= '0;
            skid_state_q <= '0;
            skid_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            main_state_q <= main_state_d;
            main_tag_q   <= main_tag_d;
            skid_state_q <= skid_state_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = main_state_q;
    assign bus.out_tag   = main_tag_q;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed bench for aes_shift_rows_pipe: NB=4 and NB=8 instances, hand-computed vectors,
// back-pressure, streaming and mid-operation reset.
module tb_aes_shift_rows_pipe;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned W4    = 128;
    localparam int unsigned W8    = 256;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [0:W4-1] vec_a;
    logic [0:W4-1] fwd_a;
    logic [0:W4-1] inv_a;
    logic [0:W8-1] idx8;
    logic [0:W8-1] fwd8;

    aes_shift_rows_pipe_if #(.NB(4), .TAG_W(TAG_W)) if4 ();
    aes_shift_rows_pipe_if #(.NB(8), .TAG_W(TAG_W)) if8 ();

    aes_shift_rows_pipe #(.NB(4), .TAG_W(TAG_W)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    aes_shift_rows_pipe #(.NB(8), .TAG_W(TAG_W)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle4();
        if4.in_valid  = 1'b0;
        if4.in_state  = '0;
        if4.in_inv    = 1'b0;
        if4.in_tag    = '0;
        if4.out_ready = 1'b1;
    endtask

    task automatic idle8();
        if8.in_valid  = 1'b0;
        if8.in_state  = '0;
        if8.in_inv    = 1'b0;
        if8.in_tag    = '0;
        if8.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle4();
        idle8();
        repeat (3) @(negedge clk);
        n_checks++; if (if4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", if4.in_ready); end
        n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", if4.out_valid); end
        n_checks++; if (if4.out_state !== '0) begin n_fail++; $display("FAIL reset_out_state: got %h want 0", if4.out_state); end
        n_checks++; if (if4.out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", if4.out_tag); end
        n_checks++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_nb8: got valid=%b ready=%b want 0/1", if8.out_valid, if8.in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fwd_nb4();
        if4.in_valid = 1'b1;
        if4.in_state = vec_a;
        if4.in_inv   = 1'b0;
        if4.in_tag   = 4'h5;
        @(negedge clk);
        idle4();
        n_checks++; if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL fwd4_latency: got out_valid=%b want 1", if4.out_valid); end
        n_checks++; if (if4.out_state !== fwd_a) begin n_fail++; $display("FAIL fwd4_state: got %h want %h", if4.out_state, fwd_a); end
        n_checks++; if (if4.out_tag !== 4'h5) begin n_fail++; $display("FAIL fwd4_tag: got %h want 5", if4.out_tag); end
        @(negedge clk);
        n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL fwd4_drain: got out_valid=%b want 0", if4.out_valid); end
    endtask

    task automatic test_inv_nb4();
        logic [0:W4-1] x;
        logic [0:W4-1] y;
        if4.in_valid = 1'b1;
        if4.in_state = fwd_a;
        if4.in_inv   = 1'b1;
        if4.in_tag   = 4'h9;
        @(negedge clk);
        if4.in_state = vec_a;
        if4.in_tag   = 4'h3;
        n_checks++; if (if4.out_state !== vec_a || if4.out_tag !== 4'h9) begin
            n_fail++; $display("FAIL inv4_roundtrip: got %h/%h want %h/9", if4.out_state, if4.out_tag, vec_a);
        end
        @(negedge clk);
        idle4();
        n_checks++; if (if4.out_state !== inv_a || if4.out_tag !== 4'h3) begin
            n_fail++; $display("FAIL inv4_direct: got %h/%h want %h/3", if4.out_state, if4.out_tag, inv_a);
        end
        @(negedge clk);
        // Random fwd then inv must give back the original state.
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            if4.in_valid = 1'b1;
            if4.in_state = x;
            if4.in_inv   = 1'b0;
            if4.in_tag   = 4'(i);
            @(negedge clk);
            y = if4.out_state;
            if4.in_state = y;
            if4.in_inv   = 1'b1;
            @(negedge clk);
            n_checks++; if (if4.out_valid !== 1'b1 || if4.out_state !== x) begin
                n_fail++; $display("FAIL rand_identity[%0d]: got %h want %h", i, if4.out_state, x);
            end
        end
        idle4();
        @(negedge clk);
    endtask

    task automatic test_nb8();
        logic [0:31] col0;
        if8.in_valid = 1'b1;
        if8.in_state = idx8;
        if8.in_inv   = 1'b0;
        if8.in_tag   = 4'hc;
        @(negedge clk);
        if8.in_state = fwd8;
        if8.in_inv   = 1'b1;
        if8.in_tag   = 4'hd;
        col0 = if8.out_state[0:31];
        n_checks++; if (col0 !== 32'h00050e13) begin n_fail++; $display("FAIL nb8_col0: got %h want 00050e13", col0); end
        n_checks++; if (if8.out_state !== fwd8 || if8.out_tag !== 4'hc) begin
            n_fail++; $display("FAIL nb8_fwd: got %h/%h want %h/c", if8.out_state, if8.out_tag, fwd8);
        end
        @(negedge clk);
        idle8();
        n_checks++; if (if8.out_state !== idx8 || if8.out_tag !== 4'hd) begin
            n_fail++; $display("FAIL nb8_inv: got %h/%h want %h/d", if8.out_state, if8.out_tag, idx8);
        end
        @(negedge clk);
        n_checks++; if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL nb8_drain: got out_valid=%b want 0", if8.out_valid); end
    endtask

    task automatic test_back_pressure();
        if4.out_ready = 1'b0;
        if4.in_valid  = 1'b1;
        if4.in_state  = vec_a;
        if4.in_inv    = 1'b0;
        if4.in_tag    = 4'h1;
        @(negedge clk);
        n_checks++; if (if4.out_valid !== 1'b1 || if4.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_one: got valid=%b ready=%b want 1/1", if4.out_valid, if4.in_ready);
        end
        if4.in_state = fwd_a;
        if4.in_inv   = 1'b1;
        if4.in_tag   = 4'h2;
        @(negedge clk);
        n_checks++; if (if4.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", if4.in_ready); end
        n_checks++; if (if4.out_state !== fwd_a || if4.out_tag !== 4'h1) begin
            n_fail++; $display("FAIL bp_head_a: got %h/%h want %h/1", if4.out_state, if4.out_tag, fwd_a);
        end
        if4.in_state = vec_a;
        if4.in_inv   = 1'b1;
        if4.in_tag   = 4'h3;
        @(negedge clk);
        n_checks++; if (if4.in_ready !== 1'b0 || if4.out_tag !== 4'h1 || if4.out_state !== fwd_a) begin
            n_fail++; $display("FAIL bp_hold: got ready=%b tag=%h want 0/1", if4.in_ready, if4.out_tag);
        end
        if4.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (if4.out_state !== vec_a || if4.out_tag !== 4'h2 || if4.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_b: got %h/%h ready=%b want %h/2 ready=1", if4.out_state, if4.out_tag, if4.in_ready, vec_a);
        end
        @(negedge clk);
        idle4();
        n_checks++; if (if4.out_valid !== 1'b1 || if4.out_state !== inv_a || if4.out_tag !== 4'h3) begin
            n_fail++; $display("FAIL bp_c: got %h/%h want %h/3", if4.out_state, if4.out_tag, inv_a);
        end
        @(negedge clk);
        n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got out_valid=%b want 0", if4.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [0:W4-1]    exp_q[$];
        logic [TAG_W-1:0] tag_q[$];
        logic [0:W4-1]    e;
        logic [TAG_W-1:0] t;
        int popped;
        int budget;
        popped = 0;
        for (int i = 0; i < 50; i++) begin
            if4.in_valid  = 1'b1;
            if4.in_inv    = i[0];
            if4.in_state  = i[0] ? fwd_a : vec_a;
            if4.in_tag    = 4'(i);
            if4.out_ready = 1'b1;
            n_checks++; if (if4.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, if4.in_ready); end
            if (i > 0) begin
                n_checks++; if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_bubble[%0d]: got out_valid=%b want 1", i, if4.out_valid); end
            end
            if (if4.out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra[%0d]: got tag %h want no beat", i, if4.out_tag);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    popped++;
                    if (if4.out_state !== e || if4.out_tag !== t) begin
                        n_fail++; $display("FAIL stream_data[%0d]: got %h/%h want %h/%h", i, if4.out_state, if4.out_tag, e, t);
                    end
                end
            end
            if (if4.in_ready === 1'b1) begin
                exp_q.push_back(i[0] ? vec_a : fwd_a);
                tag_q.push_back(4'(i));
            end
            @(negedge clk);
        end
        idle4();
        budget = 0;
        while (exp_q.size() > 0 && budget < 5) begin
            if (if4.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                popped++;
                n_checks++; if (if4.out_state !== e || if4.out_tag !== t) begin
                    n_fail++; $display("FAIL stream_tail: got %h/%h want %h/%h", if4.out_state, if4.out_tag, e, t);
                end
            end
            budget++;
            @(negedge clk);
        end
        n_checks++; if (popped != 50) begin n_fail++; $display("FAIL stream_count: got %0d want 50", popped); end
        n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got out_valid=%b want 0", if4.out_valid); end
    endtask

    task automatic test_reset_mid();
        if4.out_ready = 1'b0;
        if4.in_valid  = 1'b1;
        if4.in_state  = vec_a;
        if4.in_inv    = 1'b0;
        if4.in_tag    = 4'h1;
        @(negedge clk);
        if4.in_state = fwd_a;
        if4.in_inv   = 1'b1;
        if4.in_tag   = 4'h2;
        @(negedge clk);
        if4.in_valid = 1'b0;
        n_checks++; if (if4.out_valid !== 1'b1 || if4.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_full: got valid=%b ready=%b want 1/0", if4.out_valid, if4.in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_async: got valid=%b ready=%b want 0/1", if4.out_valid, if4.in_ready);
        end
        n_checks++; if (if4.out_state !== '0 || if4.out_tag !== '0) begin
            n_fail++; $display("FAIL rstmid_data: got %h/%h want 0/0", if4.out_state, if4.out_tag);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        if4.in_valid  = 1'b1;
        if4.in_state  = vec_a;
        if4.in_inv    = 1'b1;
        if4.in_tag    = 4'h7;
        if4.out_ready = 1'b1;
        @(negedge clk);
        idle4();
        n_checks++; if (if4.out_valid !== 1'b1 || if4.out_state !== inv_a || if4.out_tag !== 4'h7) begin
            n_fail++; $display("FAIL rstmid_first: got valid=%b %h/%h want 1 %h/7", if4.out_valid, if4.out_state, if4.out_tag, inv_a);
        end
        @(negedge clk);
        n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drain: got out_valid=%b want 0", if4.out_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vec_a = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
        fwd_a = 128'hd4b411e5_e0419830_b8275dae_1ebf52f1;
        inv_a = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
        fwd8  = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
        for (int k = 0; k < 32; k++) begin
            idx8[8*k +: 8] = 8'(k);
        end

        test_reset();
        test_fwd_nb4();
        test_inv_nb4();
        test_nb8();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
